inst_fetch_queue: RTL

- Parametrised instruction prefetch queue placed between the inst SRAM port and ID.
- Replaces the single-register IF→ID handoff with a DEPTH-entry FIFO of {pc, inst}.
- Keeps fetching while ID stalls, so a stall does not bubble the front end.
- Handles branch redirect by flushing queued entries and the in-flight request.

---
 rtl/inst_fetch_queue.sv | 76 +++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: DEPTH-entry {pc, inst} prefetch FIFO between inst SRAM and ID with redirect flush.
// Optional same-cycle bypass of an empty queue under macro FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'hBFC0_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_e,
  input  logic [PC_W-1:0]   br_addr,
  output logic              inst_sram_en,
  output logic [3:0]        inst_sram_wen,
  output logic [PC_W-1:0]   inst_sram_addr,
  output logic [31:0]       inst_sram_wdata,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PC_W-1:0] pc, req_pc, target;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic inflight, issue, push, pop, byp;
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  assign target = br_addr & ~PC_W'(3);
  // credit for the in-flight word is reserved at issue, so a return never overflows
  assign issue = ({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH);
  assign inst_sram_en = rst & (br_e | issue);
  assign inst_sram_addr = br_e ? target : pc;
  assign inst_sram_wen = 4'b0;
  assign inst_sram_wdata = 32'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count == '0) & inflight & ~br_e;
`else
  assign byp = 1'b0;
`endif
  assign push = inflight & ~br_e & ~(byp & out_ready);
  assign pop = (count != '0) & out_ready & ~br_e;
  assign out_valid = rst & ((count != '0) | byp);
  assign out_pc = !rst ? '0 : byp ? req_pc : mem_pc[rd_ptr];
  assign out_inst = !rst ? '0 : byp ? inst_sram_rdata : mem_inst[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      inflight <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= inst_sram_en;
      if (inst_sram_en) begin
        pc <= inst_sram_addr + PC_W'(4);
        req_pc <= inst_sram_addr;
      end
      if (br_e) begin
        count <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_pc[wr_ptr] <= req_pc;
      mem_inst[wr_ptr] <= inst_sram_rdata;
    end
endmodule
